// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: drives latchn/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_mispredict,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_i,
  output logic        pc_latchn,
  output logic        ifid_latchn,
  output logic        idex_latchn,
  output logic        exmem_latchn,
  output logic        memwb_latchn,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [2:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LDSTALL = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [1:0] fcnt_q, fcnt_d;

  logic lu, mw;
  logic hold_all, hold_front, ifid_fl, idex_fl;

  assign lu = ex_is_load & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mw = mem_req & ~mem_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    fcnt_d     = fcnt_q;
    hold_all   = 1'b0;
    hold_front = 1'b0;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_i) begin
          hold_all = 1'b1;
          state_d  = ST_HALT;
        end else if (mw) begin
          hold_all = 1'b1;
          ret_d    = ST_RUN;
          state_d  = ST_MEMWAIT;
        end else if (ex_mispredict) begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
          fcnt_d  = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else if (lu) begin
          hold_front = 1'b1;
          idex_fl    = 1'b1;
          state_d    = ST_LDSTALL;
        end
      end
      // EX already holds the bubble, so a load-use match is stale here.
      ST_LDSTALL: begin
        if (halt_i) begin
          hold_all = 1'b1;
          state_d  = ST_HALT;
        end else if (mw) begin
          hold_all = 1'b1;
          ret_d    = ST_RUN;
          state_d  = ST_MEMWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (halt_i) begin
          hold_all = 1'b1;
          state_d  = ST_HALT;
        end else if (mw) begin
          hold_all = 1'b1;
          ret_d    = ST_FLUSH;
          state_d  = ST_MEMWAIT;
        end else begin
          ifid_fl = 1'b1;
          if (fcnt_q == 2'd1) state_d = ST_RUN;
          else                fcnt_d  = fcnt_q - 2'd1;
        end
      end
      ST_MEMWAIT: begin
        if (!mem_ready) hold_all = 1'b1;
        else            state_d  = ret_q;
      end
      ST_HALT: hold_all = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Reset forces every register to hold and suppresses bubbles without waiting for an edge.
  assign pc_latchn    = ~RSTn | hold_all | hold_front;
  assign ifid_latchn  = ~RSTn | hold_all | hold_front;
  assign idex_latchn  = ~RSTn | hold_all;
  assign exmem_latchn = ~RSTn | hold_all;
  assign memwb_latchn = ~RSTn | hold_all;
  assign ifid_flush   = RSTn & ifid_fl;
  assign idex_flush   = RSTn & idex_fl;
  assign state_o      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        accept_mp;

  assign accept_mp = (state_q == ST_RUN) & ~halt_i & ~mw & ex_mispredict;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (pc_latchn && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (accept_mp && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES = 2): directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict;
  logic        mem_req, mem_ready, halt_i;
  logic        pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn;
  logic        ifid_flush, idex_flush;
  logic [2:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_i(halt_i),
    .pc_latchn(pc_latchn), .ifid_latchn(ifid_latchn), .idex_latchn(idex_latchn),
    .exmem_latchn(exmem_latchn), .memwb_latchn(memwb_latchn),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  wire [4:0] lat = {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn};
  wire [1:0] fl  = {ifid_flush, idex_flush};

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_mispredict = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 1'b0;
    #13;
    n_cmp++;
    if (lat !== 5'b11111 || fl !== 2'b00 || state_o !== 3'd0 ||
        stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL reset: lat=%b fl=%b st=%0d sc=%0d fc=%0d, want 11111 00 0 0 0",
               lat, fl, state_o, stall_cnt_o, flush_cnt_o);
    end
    do_reset();
    @(negedge CLK);
    n_cmp++;
    if (lat !== 5'b00000 || fl !== 2'b00 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: lat=%b fl=%b st=%0d, want 00000 00 0", lat, fl, state_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (lat !== 5'b11000 || fl !== 2'b01 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL lu_detect: lat=%b fl=%b st=%0d, want 11000 01 0", lat, fl, state_o);
    end
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0;
    @(negedge CLK);
    n_cmp++;
    if (lat !== 5'b00000 || fl !== 2'b00 || state_o !== 3'd1) begin
      n_err++;
      $display("FAIL lu_bubble: lat=%b fl=%b st=%0d, want 00000 00 1", lat, fl, state_o);
    end
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs2 = 1'b1; id_rs2 = 5'd0;
    @(negedge CLK);
    n_cmp++;
    if (lat !== 5'b00000 || fl !== 2'b00 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL lu_x0: lat=%b fl=%b st=%0d, want 00000 00 0", lat, fl, state_o);
    end
    tick();
    n_cmp++;
    if (state_o !== 3'd0 || stall_cnt_o !== (PERF ? 16'd1 : 16'd0)) begin
      n_err++;
      $display("FAIL lu_after: st=%0d sc=%0d, want 0 %0d", state_o, stall_cnt_o, PERF ? 1 : 0);
    end
  endtask

  task automatic test_mispredict();
    int n_iff, n_idf;
    int st_seq [4];
    n_iff = 0; n_idf = 0;
    do_reset();
    ex_mispredict = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c < 4) st_seq[c] = int'(state_o);
      if (ifid_flush) n_iff++;
      if (idex_flush) n_idf++;
      if (lat !== 5'b00000) begin
        n_cmp++; n_err++;
        $display("FAIL mp_latch: cycle %0d lat=%b, want 00000", c, lat);
      end
      tick();
      ex_mispredict = 1'b0;
    end
    n_cmp++;
    if (n_iff != FC + 1 || n_idf != 1) begin
      n_err++;
      $display("FAIL mp_flush_len: ifid=%0d idex=%0d, want %0d 1", n_iff, n_idf, FC + 1);
    end
    n_cmp++;
    if (st_seq[0] != 0 || st_seq[1] != 2 || st_seq[2] != 2 || st_seq[3] != 0) begin
      n_err++;
      $display("FAIL mp_states: %0d %0d %0d %0d, want 0 2 2 0", st_seq[0], st_seq[1], st_seq[2], st_seq[3]);
    end
    n_cmp++;
    if (flush_cnt_o !== (PERF ? 16'd1 : 16'd0) || stall_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL mp_counters: fc=%0d sc=%0d, want %0d 0", flush_cnt_o, stall_cnt_o, PERF ? 1 : 0);
    end
  endtask

  task automatic test_memwait();
    int n_hold;
    n_hold = 0;
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) mem_ready = 1'b1;
      if (c == 5) begin mem_req = 1'b0; mem_ready = 1'b0; end
      @(negedge CLK);
      if (lat === 5'b11111) n_hold++;
      if ((c >= 1 && c <= 4 && state_o !== 3'd3) || (c >= 5 && state_o !== 3'd0) || fl !== 2'b00) begin
        n_cmp++; n_err++;
        $display("FAIL mw_state: cycle %0d st=%0d fl=%b", c, state_o, fl);
      end
      tick();
    end
    n_cmp++;
    if (n_hold != 4) begin
      n_err++;
      $display("FAIL mw_hold_len: %0d cycles held, want 4", n_hold);
    end
    n_cmp++;
    if (stall_cnt_o !== (PERF ? 16'd4 : 16'd0)) begin
      n_err++;
      $display("FAIL mw_stall_cnt: %0d, want %0d", stall_cnt_o, PERF ? 4 : 0);
    end
  endtask

  task automatic test_mp_lu_then_mw();
    // {state, latches, flushes} per cycle
    logic [2:0] exp_st  [7] = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd0};
    logic [4:0] exp_lat [7] = '{5'b00000, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [1:0] exp_fl  [7] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
    do_reset();
    ex_mispredict = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        ex_mispredict = 1'b0; ex_is_load = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
      end
      if (c == 3) mem_ready = 1'b1;
      if (c == 4) begin mem_req = 1'b0; mem_ready = 1'b0; end
      @(negedge CLK);
      n_cmp++;
      if (state_o !== exp_st[c] || lat !== exp_lat[c] || fl !== exp_fl[c]) begin
        n_err++;
        $display("FAIL mp_lu_mw: cycle %0d st=%0d lat=%b fl=%b, want %0d %b %b",
                 c, state_o, lat, fl, exp_st[c], exp_lat[c], exp_fl[c]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp_sc;
    exp_sc = PERF ? 16'd1 : 16'd0;
    do_reset();
    halt_i = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (lat !== 5'b11111 || fl !== 2'b00) begin
      n_err++;
      $display("FAIL halt_entry: lat=%b fl=%b, want 11111 00", lat, fl);
    end
    tick();
    halt_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ex_mispredict = 1'($urandom); mem_req = 1'($urandom); mem_ready = 1'($urandom);
      ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (state_o !== 3'd4 || lat !== 5'b11111 || fl !== 2'b00 || stall_cnt_o !== exp_sc) begin
        n_err++;
        $display("FAIL halt_sticky: cycle %0d st=%0d lat=%b fl=%b sc=%0d, want 4 11111 00 %0d",
                 c, state_o, lat, fl, stall_cnt_o, exp_sc);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    ex_mispredict = 1'b1;
    tick();
    ex_mispredict = 1'b0;
    #2;
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_err++;
      $display("FAIL rst_pre: st=%0d, want 2", state_o);
    end
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || lat !== 5'b11111 || fl !== 2'b00 ||
        stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_flush: st=%0d lat=%b fl=%b sc=%0d fc=%0d, want 0 11111 00 0 0",
               state_o, lat, fl, stall_cnt_o, flush_cnt_o);
    end
    do_reset();
  endtask

  // Random traffic against a behavioural model of the pipeline's stall/flush rules.
  task automatic test_random();
    int mode, left, resume, stalls, flushes;
    bit hazard, memwait;
    logic [4:0] e_lat;
    logic [1:0] e_fl;
    int nxt;
    do_reset();
    mode = 0; left = 0; resume = 0; stalls = 0; flushes = 0;
    for (int c = 0; c < 500; c++) begin
      ex_rd         = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_uses_rs1   = 1'($urandom);
      id_uses_rs2   = 1'($urandom);
      ex_is_load    = 1'($urandom);
      ex_mispredict = ($urandom_range(0, 7) == 0);
      mem_req       = ($urandom_range(0, 4) == 0);
      mem_ready     = ($urandom_range(0, 2) != 0);
      halt_i        = 1'b0;
      hazard  = ex_is_load && ex_rd != 0 &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      memwait = mem_req && !mem_ready;
      e_lat = 5'b00000; e_fl = 2'b00; nxt = mode;
      if (mode == 3) begin
        if (!mem_ready) e_lat = 5'b11111;
        else            nxt = resume;
      end else if (memwait) begin
        e_lat = 5'b11111; resume = (mode == 2) ? 2 : 0; nxt = 3;
      end else if (mode == 0 && ex_mispredict) begin
        e_fl = 2'b11; left = FC; nxt = 2; flushes++;
      end else if (mode == 0 && hazard) begin
        e_lat = 5'b11000; e_fl = 2'b01; nxt = 1;
      end else if (mode == 1) begin
        nxt = 0;
      end else if (mode == 2) begin
        e_fl = 2'b10;
        left--;
        if (left == 0) nxt = 0;
      end
      if (e_lat[4]) stalls++;
      @(negedge CLK);
      n_cmp++;
      if (state_o !== 3'(mode) || lat !== e_lat || fl !== e_fl) begin
        n_err++;
        $display("FAIL rand_ctrl: cycle %0d st=%0d lat=%b fl=%b, want %0d %b %b",
                 c, state_o, lat, fl, mode, e_lat, e_fl);
      end
      tick();
      mode = nxt;
      n_cmp++;
      if (stall_cnt_o !== (PERF ? 16'(stalls) : 16'd0) || flush_cnt_o !== (PERF ? 16'(flushes) : 16'd0)) begin
        n_err++;
        $display("FAIL rand_cnt: cycle %0d sc=%0d fc=%0d, want %0d %0d",
                 c, stall_cnt_o, flush_cnt_o, PERF ? stalls : 0, PERF ? flushes : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_memwait();
    test_mp_lu_then_mw();
    test_halt();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
